// File: rtl/sha256_job_scheduler.sv
// sha256_job_scheduler
//   Queues hash jobs (message address, output address) in a small FIFO and
//   hands each one to a free SHA-256 core, using round-robin arbitration.
//   Each finished job is reported as a one-cycle completion pulse.
//
// Optional feature macro: SCHED_TIMEOUT_EN
//   When defined, each core gets a per-job watchdog. On expiry the watchdog
//   sets a sticky timeout_err bit and forces the job to complete.
//   When undefined, timeout_err is tied to 0.
//
// Ports
//   clk, reset               clock; asynchronous active-high reset
//   job_valid/job_ready      job push handshake (job_ready = FIFO not full)
//   job_msg_addr/out_addr    job payload
//   core_start[i]            one-cycle start pulse to core i
//   core_message_addr        16 bits per core, core i at [16i+15:16i]
//   core_output_addr         same packing as core_message_addr
//   core_done[i]             core level, high while core i is idle
//   cmpl_valid/core/out_addr registered completion report
//   sched_idle               FIFO empty and all cores free
//   jobs_done_cnt            wrapping count of completions
//   timeout_err[i]           sticky watchdog flag per core

// Per-core tracker: owns the job addresses and follows one core through a job.
module sha256_job_scheduler_slot #(
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        grant,
    input  logic        report,
    input  logic        done,
    input  logic [15:0] msg_in,
    input  logic [15:0] out_in,
    output logic        free,
    output logic        pend,
    output logic        start,
    output logic [15:0] msg_addr,
    output logic [15:0] out_addr,
    output logic        timeout_err
);
    typedef enum logic [2:0] {
        S_FREE, S_START, S_WAIT_LOW, S_BUSY, S_DONE_PEND
    } state_t;

    state_t state, state_nxt;
    logic   expired;

`ifdef SCHED_TIMEOUT_EN
    logic [15:0] wd_cnt;
    logic        err_q;
    logic        running;

    assign running = (state == S_WAIT_LOW) || (state == S_BUSY);
    assign expired = running && (wd_cnt == 16'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (grant)
                wd_cnt <= '0;
            else if (running && !expired)
                wd_cnt <= wd_cnt + 16'd1;
            if (expired)
                err_q <= 1'b1;
        end
    end

    assign timeout_err = err_q;
`else
    assign expired     = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FREE;
        else       state <= state_nxt;
    end

    // Addresses are held from grant until the next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_addr <= '0;
            out_addr <= '0;
        end else if (grant) begin
            msg_addr <= msg_in;
            out_addr <= out_in;
        end
    end

    // Next state. The core's done line may still be high from the previous
    // job, so it must be seen low (WAIT_LOW) before a rising done counts.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FREE:      if (grant)  state_nxt = S_START;
            S_START:                 state_nxt = S_WAIT_LOW;
            S_WAIT_LOW:  if (!done)  state_nxt = S_BUSY;
            S_BUSY:      if (done)   state_nxt = S_DONE_PEND;
            S_DONE_PEND: if (report) state_nxt = S_FREE;
            default:                 state_nxt = S_FREE;
        endcase
        if (expired) state_nxt = S_DONE_PEND;
    end

    // Outputs
    always_comb begin
        free  = (state == S_FREE);
        pend  = (state == S_DONE_PEND);
        start = (state == S_START);
    end
endmodule

module sha256_job_scheduler #(
    parameter int NUM_CORES      = 4,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 2048
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    job_valid,
    output logic                    job_ready,
    input  logic [15:0]             job_msg_addr,
    input  logic [15:0]             job_out_addr,
    output logic [NUM_CORES-1:0]    core_start,
    output logic [16*NUM_CORES-1:0] core_message_addr,
    output logic [16*NUM_CORES-1:0] core_output_addr,
    input  logic [NUM_CORES-1:0]    core_done,
    output logic                    cmpl_valid,
    output logic [2:0]              cmpl_core,
    output logic [15:0]             cmpl_out_addr,
    output logic                    sched_idle,
    output logic [15:0]             jobs_done_cnt,
    output logic [NUM_CORES-1:0]    timeout_err
);
    localparam int          AW       = $clog2(FIFO_DEPTH);
    localparam int          CW       = $clog2(NUM_CORES);
    localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

    logic [15:0]          fifo_msg [FIFO_DEPTH];
    logic [15:0]          fifo_out [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [AW:0]          count;
    logic                 fifo_empty, push, pop;

    logic [NUM_CORES-1:0] free, pend, grant, report;
    logic [15:0]          out_arr [NUM_CORES];
    logic [CW-1:0]        rr_ptr, grant_idx, report_idx, idx_c;
    logic                 grant_any, report_any;

    assign fifo_empty = (count == '0);
    // No bypass: a full FIFO refuses a push even if it pops on the same edge.
    assign job_ready  = (count != FULL_CNT);
    assign push       = job_valid && job_ready;
    assign pop        = !fifo_empty && grant_any;
    assign sched_idle = fifo_empty && (&free);

    // Round-robin search: first free core at rr_ptr, rr_ptr+1, ...
    // Walking downward lets the lowest offset win.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        idx_c     = '0;
        for (int k = NUM_CORES - 1; k >= 0; k--) begin
            idx_c = CW'((int'(rr_ptr) + k) % NUM_CORES);
            if (free[idx_c]) begin
                grant_any = 1'b1;
                grant_idx = idx_c;
            end
        end
        grant = '0;
        if (pop) grant[grant_idx] = 1'b1;
    end

    // Completion: lowest-index pending core is reported first.
    always_comb begin
        report_any = 1'b0;
        report_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (pend[i]) begin
                report_any = 1'b1;
                report_idx = CW'(i);
            end
        end
        report = '0;
        if (report_any) report[report_idx] = 1'b1;
    end

    // FIFO storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_msg[wr_ptr] <= job_msg_addr;
            fifo_out[wr_ptr] <= job_out_addr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            rr_ptr        <= '0;
            cmpl_valid    <= 1'b0;
            cmpl_core     <= '0;
            cmpl_out_addr <= '0;
            jobs_done_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (pop)
                rr_ptr <= (grant_idx == CW'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
            cmpl_valid    <= report_any;
            cmpl_core     <= report_any ? 3'(report_idx) : 3'd0;
            cmpl_out_addr <= report_any ? out_arr[report_idx] : 16'd0;
            if (report_any)
                jobs_done_cnt <= jobs_done_cnt + 16'd1;
        end
    end

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
        sha256_job_scheduler_slot #(
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_slot (
            .clk         (clk),
            .reset       (reset),
            .grant       (grant[g]),
            .report      (report[g]),
            .done        (core_done[g]),
            .msg_in      (fifo_msg[rd_ptr]),
            .out_in      (fifo_out[rd_ptr]),
            .free        (free[g]),
            .pend        (pend[g]),
            .start       (core_start[g]),
            .msg_addr    (core_message_addr[16*g +: 16]),
            .out_addr    (out_arr[g]),
            .timeout_err (timeout_err[g])
        );
        assign core_output_addr[16*g +: 16] = out_arr[g];
    end
endmodule

// File: tb/tb_sha256_job_scheduler.sv
// Bench for sha256_job_scheduler: behavioural core models plus two
// scoreboards. One holds the expected grants (core, message address). The
// other holds the expected completions (core, output address).
module tb_sha256_job_scheduler;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             job_valid = 1'b0;
    logic [15:0]      job_msg_addr = '0;
    logic [15:0]      job_out_addr = '0;
    logic             job_ready;
    logic [N-1:0]     core_start;
    logic [16*N-1:0]  core_message_addr, core_output_addr;
    logic [N-1:0]     core_done = '1;
    logic             cmpl_valid;
    logic [2:0]       cmpl_core;
    logic [15:0]      cmpl_out_addr;
    logic             sched_idle;
    logic [15:0]      jobs_done_cnt;
    logic [N-1:0]     timeout_err;

    sha256_job_scheduler #(.NUM_CORES(N), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(64)) dut (
        .clk(clk), .reset(reset),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_msg_addr(job_msg_addr), .job_out_addr(job_out_addr),
        .core_start(core_start), .core_message_addr(core_message_addr),
        .core_output_addr(core_output_addr), .core_done(core_done),
        .cmpl_valid(cmpl_valid), .cmpl_core(cmpl_core), .cmpl_out_addr(cmpl_out_addr),
        .sched_idle(sched_idle), .jobs_done_cnt(jobs_done_cnt), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {int core; logic [15:0] addr;} exp_t;
    exp_t sb[$];
    exp_t gq[$];
    int   start_cyc[$];
    int   cmpl_cyc[$];
    int   n_chk = 0, n_fail = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core model: on start, done holds high for stale[i] extra cycles, then
    // drops and rises lat[i] cycles later (never, if stuck[i]).
    int lat[N], stale[N], ctr[N], phase[N];
    bit stuck[N];

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (core_start[i]) begin
                phase[i] = 1;
                ctr[i]   = stale[i];
            end else if (phase[i] == 1) begin
                if (ctr[i] == 0) begin
                    core_done[i] = 1'b0;
                    phase[i]     = 2;
                    ctr[i]       = lat[i];
                end else ctr[i]--;
            end else if (phase[i] == 2) begin
                if (ctr[i] == 0 && !stuck[i]) begin
                    core_done[i] = 1'b1;
                    phase[i]     = 0;
                end else if (ctr[i] > 0) ctr[i]--;
            end
        end
    end

    // Monitor: checks grants and completions against the scoreboards.
    logic [N-1:0] prev_start = '0;
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (cmpl_valid) begin
            cmpl_cyc.push_back(cyc);
            if (sb.size() == 0) chk("cmpl_unexpected", 1, 0);
            else begin
                e = sb.pop_front();
                chk("cmpl_core", 32'(cmpl_core), e.core);
                chk("cmpl_addr", 32'(cmpl_out_addr), 32'(e.addr));
            end
        end
        for (int i = 0; i < N; i++) begin
            if (core_start[i]) begin
                start_cyc.push_back(cyc);
                chk("start_width", 32'(prev_start[i]), 0);
                if (gq.size() == 0) chk("start_unexpected", 1, 0);
                else begin
                    e = gq.pop_front();
                    chk("grant_core", i, e.core);
                    chk("grant_msg", 32'(core_message_addr[16*i +: 16]), 32'(e.addr));
                end
            end
        end
        prev_start = core_start;
    end

    task automatic expect_job(input int core, input logic [15:0] m, input logic [15:0] o);
        exp_t e;
        e.core = core; e.addr = m; gq.push_back(e);
        e.addr = o;    sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push(input logic [15:0] m, input logic [15:0] o);
        int n = 0;
        job_msg_addr = m;
        job_out_addr = o;
        job_valid    = 1'b1;
        while (!job_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!job_ready) chk("push_timeout", 0, 1);
        else @(negedge clk);
        job_valid = 1'b0;
    endtask

    task automatic drain(input string tag, input int max);
        int n = 0;
        while ((sb.size() != 0 || gq.size() != 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, sb.size() + gq.size(), 0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int b, early;
        for (int i = 0; i < N; i++) begin
            lat[i] = 20; stale[i] = 0; ctr[i] = 0; phase[i] = 0; stuck[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        // Reset state
        chk("rst_ready", 32'(job_ready), 1);
        chk("rst_idle", 32'(sched_idle), 1);
        chk("rst_start", 32'(core_start), 0);
        chk("rst_cmpl", 32'(cmpl_valid), 0);
        chk("rst_cnt", 32'(jobs_done_cnt), 0);
        chk("rst_tmo", 32'(timeout_err), 0);
        reset = 1'b0;
        @(negedge clk);

        // 1: single job, start one cycle after the push
        lat[0] = 150;
        expect_job(0, 16'h0000, 16'h0100);
        push(16'h0000, 16'h0100);
        chk("t1_start_early", 32'(core_start), 0);
        @(negedge clk);
        chk("t1_start", 32'(core_start), 32'b0001);
        drain("t1_drain", 300);
        @(negedge clk);
        chk("t1_cnt", 32'(jobs_done_cnt), 1);
        chk("t1_idle", 32'(sched_idle), 1);

        // 2: round robin, six back-to-back jobs
        pulse_reset();
        for (int i = 0; i < N; i++) lat[i] = 20;
        b = start_cyc.size();
        for (int j = 0; j < 6; j++)
            expect_job(j % 4, 16'(16'h2000 + j), 16'(16'h2100 + j));
        for (int j = 0; j < 6; j++) begin
            chk("t2_ready", 32'(job_ready), 1);
            push(16'(16'h2000 + j), 16'(16'h2100 + j));
        end
        chk("t2_ready_end", 32'(job_ready), 1);
        drain("t2_drain", 200);
        for (int k = 1; k < 4; k++)
            chk("t2_consec", start_cyc[b+k] - start_cyc[b+k-1], 1);
        @(negedge clk);
        chk("t2_cnt", 32'(jobs_done_cnt), 6);

        // 3: FIFO full with all cores busy, order preserved
        pulse_reset();
        for (int i = 0; i < N; i++) lat[i] = 100;
        for (int j = 0; j < 4; j++) expect_job(j, 16'(16'h3000 + j), 16'(16'h3100 + j));
        for (int j = 0; j < 5; j++) expect_job(j % 4, 16'(16'h3200 + j), 16'(16'h3300 + j));
        for (int j = 0; j < 4; j++) push(16'(16'h3000 + j), 16'(16'h3100 + j));
        for (int j = 0; j < 4; j++) push(16'(16'h3200 + j), 16'(16'h3300 + j));
        chk("t3_full", 32'(job_ready), 0);
        push(16'h3204, 16'h3304);
        drain("t3_drain", 800);
        @(negedge clk);
        chk("t3_cnt", 32'(jobs_done_cnt), 9);

        // 4: cores 1 and 3 finish on the same edge
        pulse_reset();
        lat[0] = 60; lat[1] = 40; lat[2] = 60; lat[3] = 38;
        expect_job(0, 16'h4000, 16'h4100);
        expect_job(1, 16'h4001, 16'h4101);
        expect_job(2, 16'h4002, 16'h4102);
        expect_job(3, 16'h4003, 16'h4103);
        // Completion order is 1,3,0,2: reorder the completion scoreboard.
        sb.delete();
        begin
            exp_t e;
            e.core = 1; e.addr = 16'h4101; sb.push_back(e);
            e.core = 3; e.addr = 16'h4103; sb.push_back(e);
            e.core = 0; e.addr = 16'h4100; sb.push_back(e);
            e.core = 2; e.addr = 16'h4102; sb.push_back(e);
        end
        b = cmpl_cyc.size();
        for (int j = 0; j < 4; j++) push(16'(16'h4000 + j), 16'(16'h4100 + j));
        drain("t4_drain", 200);
        chk("t4_back2back", cmpl_cyc[b+1] - cmpl_cyc[b], 1);
        @(negedge clk);
        chk("t4_cnt", 32'(jobs_done_cnt), 4);

        // 5: stale done held high after start
        pulse_reset();
        lat[0] = 10; stale[0] = 3;
        expect_job(0, 16'h5000, 16'h5100);
        push(16'h5000, 16'h5100);
        early = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (cmpl_valid) early++;
        end
        chk("t5_early", early, 0);
        drain("t5_drain", 50);
        stale[0] = 0;
        @(negedge clk);
        chk("t5_cnt", 32'(jobs_done_cnt), 1);

        // 6: reset with four busy cores and two queued jobs
        pulse_reset();
        for (int i = 0; i < N; i++) lat[i] = 200;
        for (int j = 0; j < 4; j++) begin
            exp_t e;
            e.core = j; e.addr = 16'(16'h6000 + j); gq.push_back(e);
        end
        for (int j = 0; j < 6; j++) push(16'(16'h6000 + j), 16'(16'h6100 + j));
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t6_ready", 32'(job_ready), 1);
        chk("t6_idle", 32'(sched_idle), 1);
        chk("t6_start", 32'(core_start), 0);
        chk("t6_cmpl", 32'(cmpl_valid), 0);
        chk("t6_cnt", 32'(jobs_done_cnt), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (300) @(negedge clk);
        chk("t6_cnt_after", 32'(jobs_done_cnt), 0);
        chk("t6_idle_after", 32'(sched_idle), 1);
        chk("t6_gq", gq.size(), 0);

`ifdef SCHED_TIMEOUT_EN
        // 7: stuck core is forced to complete by the watchdog
        pulse_reset();
        for (int i = 0; i < N; i++) lat[i] = 20;
        stuck[0] = 1'b1;
        expect_job(0, 16'h7000, 16'h7100);
        push(16'h7000, 16'h7100);
        drain("t7_drain", 200);
        chk("t7_tmo", 32'(timeout_err), 32'b0001);
`else
        chk("tmo_tied", 32'(timeout_err), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
